// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's memory port-1, redirect and decode handshake signals.
// master = fetch_unit side, slave = memory/execute/decode environment side.
interface fetch_unit_if;
  logic        mem_en_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_busy_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        misalign_o;

  modport master (
    output mem_en_o, mem_wen_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
    input  mem_data_i, mem_busy_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  mem_en_o, mem_wen_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, misalign_o,
    output mem_data_i, mem_busy_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with busy-tolerant memory port and a small output FIFO.
// Optional misaligned-redirect trap is enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          BUF_DEPTH = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  fetch_unit_if.master bus
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] STEP_C  = AW'(1);

`ifdef FETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, RUN, FULL, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
`endif

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
`ifdef FETCH_ALIGN_CHK_EN
    return pc;
`else
    return pc & 32'hFFFF_FFFC;
`endif
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   pc_p0, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   data_p1 [BUF_DEPTH];
  logic [31:0]   pc_p1   [BUF_DEPTH];
  logic          fetch_en, push, pop, vld_p1;

  // Fetch enable is a function of state and occupancy only, never of decode ready.
  assign fetch_en = (state_q == RUN) && (cnt_q < DEPTH_C);
  assign push     = fetch_en && !bus.mem_busy_i && !bus.redirect_i;
  assign vld_p1   = (cnt_q != '0);
  assign pop      = vld_p1 && bus.instr_ready_i && !bus.redirect_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    cnt_d   = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
    if (push) pc_d = pc_p0 + 32'd4;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (cnt_d == DEPTH_C) state_d = FULL;
      FULL:    if (cnt_d < DEPTH_C) state_d = RUN;
`ifdef FETCH_ALIGN_CHK_EN
      TRAP:    state_d = TRAP;
`endif
      default: state_d = IDLE;
    endcase
    // Redirect overrides any accept/pop decided above.
    if (bus.redirect_i) begin
      cnt_d   = '0;
      pc_d    = align_pc(bus.redirect_pc_i);
      state_d = RUN;
`ifdef FETCH_ALIGN_CHK_EN
      if (bus.redirect_pc_i[1:0] != 2'b00) state_d = TRAP;
`endif
    end
  end

  // p0: control state and fetch PC
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_p0    <= align_pc(RESET_PC);
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_d;
      cnt_q   <= cnt_d;
      if (bus.redirect_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + STEP_C;
        if (pop)  rd_ptr_q <= rd_ptr_q + STEP_C;
      end
    end
  end

  // p1: FIFO storage, written on accept
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_p1[wr_ptr_q] <= bus.mem_data_i;
      pc_p1[wr_ptr_q]   <= pc_p0;
    end
  end

  assign bus.mem_en_o      = fetch_en;
  assign bus.mem_wen_o     = 1'b0;
  assign bus.mem_addr_o    = pc_p0;
  assign bus.instr_valid_o = vld_p1;
  assign bus.instr_o       = vld_p1 ? data_p1[rd_ptr_q] : '0;
  assign bus.instr_pc_o    = vld_p1 ? pc_p1[rd_ptr_q] : '0;
`ifdef FETCH_ALIGN_CHK_EN
  assign bus.misalign_o    = (state_q == TRAP);
`else
  assign bus.misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory modelled as word(addr) = (addr << 5) | 'h13,
// expected decode stream kept in a PC queue that is refilled at every redirect.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) | 32'h13;
  endfunction

  assign bus.mem_data_i = mem_word(bus.mem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Scores any handshake that completes at the coming edge, then advances one cycle.
  task automatic cyc();
    logic [31:0] exp_pc;
    if (bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
      chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'h1);
      if (sb_q.size() != 0) begin
        exp_pc = sb_q.pop_front();
        chk("pop_pc", bus.instr_pc_o, exp_pc);
        chk("pop_instr", bus.instr_o, mem_word(exp_pc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    cyc();
    bus.redirect_i = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    rst               = 1'b1;
    bus.mem_busy_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.instr_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", {31'b0, bus.mem_en_o}, 32'h0);
    chk("rst_mem_wen", {31'b0, bus.mem_wen_o}, 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    chk("rst_instr", bus.instr_o, 32'h0);
    chk("rst_instr_pc", bus.instr_pc_o, 32'h0);
    chk("rst_misalign", {31'b0, bus.misalign_o}, 32'h0);

    // Reset release: one IDLE cycle, then sequential fetch from 0
    rst = 1'b0;
    push_run(32'h0, 16);
    chk("idle_mem_en", {31'b0, bus.mem_en_o}, 32'h0);
    cyc();
    chk("first_mem_en", {31'b0, bus.mem_en_o}, 32'h1);
    chk("first_addr", bus.mem_addr_o, 32'h0);
    chk("first_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    cyc();
    chk("c3_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    chk("c3_instr", bus.instr_o, 32'h13);
    chk("c3_pc", bus.instr_pc_o, 32'h0);
    cyc();
    chk("c4_instr", bus.instr_o, 32'h93);
    chk("c4_pc", bus.instr_pc_o, 32'h4);
    cyc();
    chk("c5_instr", bus.instr_o, 32'h113);
    chk("c5_pc", bus.instr_pc_o, 32'h8);
    cyc();

    // Backpressure: FIFO fills after two accepts, fetch stalls with address held
    bus.instr_ready_i = 1'b0;
    redirect_to(32'h0);
    push_run(32'h0, 16);
    chk("bp_valid0", {31'b0, bus.instr_valid_o}, 32'h0);
    chk("bp_addr0", bus.mem_addr_o, 32'h0);
    chk("bp_en0", {31'b0, bus.mem_en_o}, 32'h1);
    cyc();
    chk("bp_addr4", bus.mem_addr_o, 32'h4);
    cyc();
    chk("full_en", {31'b0, bus.mem_en_o}, 32'h0);
    chk("full_addr", bus.mem_addr_o, 32'h8);
    cyc();
    chk("full_en_hold", {31'b0, bus.mem_en_o}, 32'h0);
    chk("full_addr_hold", bus.mem_addr_o, 32'h8);
    chk("full_head", bus.instr_pc_o, 32'h0);
    bus.instr_ready_i = 1'b1;
    cyc();
    chk("resume_en", {31'b0, bus.mem_en_o}, 32'h1);
    chk("resume_addr", bus.mem_addr_o, 32'h8);
    chk("resume_head", bus.instr_pc_o, 32'h4);
    repeat (4) cyc();

    // Memory busy for two cycles at 'h20
    bus.mem_busy_i = 1'b1;
    redirect_to(32'h20);
    push_run(32'h20, 16);
    chk("busy1_addr", bus.mem_addr_o, 32'h20);
    chk("busy1_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    cyc();
    chk("busy2_addr", bus.mem_addr_o, 32'h20);
    chk("busy2_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    cyc();
    bus.mem_busy_i = 1'b0;
    chk("busy_done_addr", bus.mem_addr_o, 32'h20);
    chk("busy_done_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    cyc();
    chk("after_busy_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    chk("after_busy_pc", bus.instr_pc_o, 32'h20);
    chk("after_busy_addr", bus.mem_addr_o, 32'h24);
    cyc();
    cyc();

    // Redirect with a full FIFO and busy memory
    bus.instr_ready_i = 1'b0;
    repeat (3) cyc();
    chk("pre_redir_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    chk("pre_redir_head", bus.instr_pc_o, 32'h28);
    bus.mem_busy_i = 1'b1;
    redirect_to(32'h100);
    bus.mem_busy_i    = 1'b0;
    bus.instr_ready_i = 1'b1;
    push_run(32'h100, 16);
    chk("redir_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    chk("redir_addr", bus.mem_addr_o, 32'h100);
    cyc();
    chk("redir_first_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    chk("redir_first_pc", bus.instr_pc_o, 32'h100);
    repeat (2) cyc();

    // PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    push_run(32'hFFFF_FFFC, 16);
    chk("wrap_addr_top", bus.mem_addr_o, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_addr_zero", bus.mem_addr_o, 32'h0);
    repeat (3) cyc();

    // Misaligned redirect
    redirect_to(32'h102);
`ifdef FETCH_ALIGN_CHK_EN
    chk("trap_misalign", {31'b0, bus.misalign_o}, 32'h1);
    chk("trap_en", {31'b0, bus.mem_en_o}, 32'h0);
    chk("trap_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    repeat (2) cyc();
    chk("trap_misalign_hold", {31'b0, bus.misalign_o}, 32'h1);
    chk("trap_en_hold", {31'b0, bus.mem_en_o}, 32'h0);
    redirect_to(32'h200);
    push_run(32'h200, 16);
    chk("untrap_misalign", {31'b0, bus.misalign_o}, 32'h0);
    chk("untrap_en", {31'b0, bus.mem_en_o}, 32'h1);
    chk("untrap_addr", bus.mem_addr_o, 32'h200);
    repeat (3) cyc();
`else
    push_run(32'h100, 16);
    chk("mis_misalign", {31'b0, bus.misalign_o}, 32'h0);
    chk("mis_en", {31'b0, bus.mem_en_o}, 32'h1);
    chk("mis_addr", bus.mem_addr_o, 32'h100);
    cyc();
    chk("mis_first_valid", {31'b0, bus.instr_valid_o}, 32'h1);
    chk("mis_first_pc", bus.instr_pc_o, 32'h100);
    repeat (2) cyc();
`endif

    // Asynchronous reset mid-operation, abandoning a busy wait
    bus.mem_busy_i = 1'b1;
    cyc();
    rst = 1'b1;
    #1;
    chk("arst_mem_en", {31'b0, bus.mem_en_o}, 32'h0);
    chk("arst_valid", {31'b0, bus.instr_valid_o}, 32'h0);
    chk("arst_addr", bus.mem_addr_o, 32'h0);
    chk("arst_instr", bus.instr_o, 32'h0);
    chk("arst_misalign", {31'b0, bus.misalign_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
